stopwatch_counter: RTL and testbench

BCD minutes:seconds time-keeping stage of the stopwatch, directly downstream of the clock divider. Consumes the divider's single-cycle `onehz` and `twohz` tick pulses plus debounced user controls. Produces four registered BCD digits (MM:SS, 00:00–59:59) and a blink flag for the display-multiplexing stage. Supports run/pause toggling and an adjust mode that steps the selected field at 2 Hz.

---
 rtl/stopwatch_counter.sv | 155 +++++++++++++++
 tb/tb_stopwatch_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS BCD time-keeping stage of the stopwatch: counts 1 Hz ticks in RUN,
// holds in PAUSED, and steps the selected field at 2 Hz with a blink flag in ADJUST.
module stopwatch_counter #(
  parameter bit START_RUNNING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       onehz,
  input  logic       twohz,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink,
  output logic       wrap
);

  typedef enum logic [1:0] {StRun, StPaused, StAdjust} state_e;

  localparam state_e ResetState = START_RUNNING ? StRun : StPaused;

  state_e     state_q, state_d;
  logic       resume_q, resume_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       running_q, running_d;
  logic       blink_q, blink_d;
  logic       wrap_q, wrap_d;

  logic       sec_at_max;
  logic       min_at_max;
  logic [7:0] sec_next;
  logic [7:0] min_next;

  // Two-digit BCD increment modulo 60: {tens, ones} in, {tens, ones} out.
  function automatic logic [7:0] inc_mod60(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones == 4'd9) begin
      if (tens == 4'd5) begin
        res = 8'h00;
      end else begin
        res = {tens + 4'd1, 4'd0};
      end
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  always_comb begin
    sec_at_max = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    min_at_max = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
    sec_next   = inc_mod60(sec_tens_q, sec_ones_q);
    min_next   = inc_mod60(min_tens_q, min_ones_q);
  end

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    blink_d    = blink_q;
    wrap_d     = 1'b0;

    case (state_q)
      StRun: begin
        // The tick is counted by the registered state even if adj/pause arrive now.
        if (onehz) begin
          {sec_tens_d, sec_ones_d} = sec_next;
          if (sec_at_max) begin
            {min_tens_d, min_ones_d} = min_next;
            wrap_d = min_at_max;
          end
        end
        if (adj) begin
          state_d  = StAdjust;
          resume_d = 1'b1;
        end else if (pause_btn) begin
          state_d = StPaused;
        end
      end

      StPaused: begin
        if (adj) begin
          state_d  = StAdjust;
          resume_d = 1'b0;
        end else if (pause_btn) begin
          state_d = StRun;
        end
      end

      StAdjust: begin
        if (twohz) begin
          if (sel) begin
            {min_tens_d, min_ones_d} = min_next;
          end else begin
            {sec_tens_d, sec_ones_d} = sec_next;
          end
          blink_d = ~blink_q;
        end
        if (!adj) begin
          state_d = resume_q ? StRun : StPaused;
          blink_d = 1'b1;
        end
      end

      default: begin
        state_d = ResetState;
      end
    endcase

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ResetState;
      resume_q   <= START_RUNNING;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      running_q  <= START_RUNNING;
      blink_q    <= 1'b1;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      running_q  <= running_d;
      blink_q    <= blink_d;
      wrap_q     <= wrap_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
  assign blink    = blink_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios then random traffic, all compared
// cycle by cycle against a reference model that keeps time as plain integers.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       onehz = 1'b0;
  logic       twohz = 1'b0;
  logic       pause_btn = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blink, wrap;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 = run, 1 = paused, 2 = adjust.
  int m_mode   = 0;
  bit m_resume = 1'b1;
  int m_min    = 0;
  int m_sec    = 0;
  bit m_blink  = 1'b1;
  bit m_wrap   = 1'b0;

  stopwatch_counter #(
    .START_RUNNING(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .onehz    (onehz),
    .twohz    (twohz),
    .pause_btn(pause_btn),
    .adj      (adj),
    .sel      (sel),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .blink    (blink),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit o, input bit t, input bit p,
                            input bit a, input bit s);
    int total;
    if (r) begin
      m_mode = 0; m_resume = 1'b1; m_min = 0; m_sec = 0; m_blink = 1'b1; m_wrap = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    if (m_mode == 0) begin
      if (o) begin
        total = m_min * 60 + m_sec + 1;
        if (total == 3600) begin
          total  = 0;
          m_wrap = 1'b1;
        end
        m_min = total / 60;
        m_sec = total % 60;
      end
      if (a) begin
        m_mode = 2; m_resume = 1'b1;
      end else if (p) begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (a) begin
        m_mode = 2; m_resume = 1'b0;
      end else if (p) begin
        m_mode = 0;
      end
    end else begin
      if (t) begin
        if (s) m_min = (m_min + 1) % 60;
        else   m_sec = (m_sec + 1) % 60;
        m_blink = !m_blink;
      end
      if (!a) begin
        m_mode  = m_resume ? 0 : 1;
        m_blink = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare 1 ns later.
  task automatic tick(input bit r, input bit o, input bit t, input bit p,
                      input bit a, input bit s);
    logic [15:0] exp_digits;
    rst = r; onehz = o; twohz = t; pause_btn = p; adj = a; sel = s;
    @(posedge clk);
    model_step(r, o, t, p, a, s);
    #1;
    exp_digits = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    check("digits", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, {16'd0, exp_digits});
    check("running", {31'd0, running}, {31'd0, m_mode == 0});
    check("blink", {31'd0, blink}, {31'd0, m_blink});
    check("wrap", {31'd0, wrap}, {31'd0, m_wrap});
  endtask

  bit r_adj = 1'b0;
  bit r_sel = 1'b0;

  initial begin
    repeat (2) tick(1, 0, 0, 0, 0, 0);
    check("reset_digits", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'd0);

    // 5 seconds in RUN.
    repeat (5) begin
      tick(0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
    end
    check("five_sec", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0005);

    // Preload 59:58 via ADJUST, then run across the wrap.
    tick(0, 0, 0, 0, 1, 1);
    repeat (59) tick(0, 0, 1, 0, 1, 1);
    repeat (53) tick(0, 0, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick(0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
    end
    check("after_wrap", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0000);

    // Coincident onehz+pause in RUN, then in PAUSED, then adj+pause.
    tick(0, 1, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 1, 0);
    repeat (3) tick(0, 1, 1, 1, 1, 1);
    tick(1, 0, 1, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_mid_adjust_blink", {31'd0, blink}, 32'd1);

    // Random traffic with slowly changing adj/sel levels.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) r_adj = !r_adj;
      if ($urandom_range(0, 19) == 0) r_sel = !r_sel;
      tick($urandom_range(0, 999) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, r_adj, r_sel);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
